dmem_access_ctrl: RTL and testbench

- Sequences a single-port synchronous data memory between two requesters: the store path (word writes) and the load path (word reads).
- Each requester gets a req/done handshake. The block latches address and data at grant and drives the memory strobes from registers.
- When both paths request in the same cycle, round-robin arbitration decides which goes first.
- Sits between the execute-stage store/load units and the data RAM. It is the only driver of the RAM address, data and enable lines.

---
 rtl/dmem_access_ctrl.sv | 162 ++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//
// Sequences a single-port synchronous data RAM between a store requester and a
// load requester. Each requester has a req/done handshake. Operands are
// captured at grant. Every RAM strobe and every handshake output comes from a
// register. When both requesters ask in the same IDLE cycle, round-robin
// arbitration picks the one that was not granted last.
//
// Ports
//   clock, reset          : system clock, synchronous active-high reset
//   st_req/st_addr/st_data: store request level plus word address and data
//   st_done               : one-cycle pulse in the cycle the store is committed
//   ld_req/ld_addr        : load request level plus word address
//   ld_data/ld_valid      : registered load result and its one-cycle pulse
//   mem_addr/mem_wdata    : registered RAM address and write data
//   mem_rdata             : RAM read data (READ_LATENCY cycles after sampling)
//   mem_ena/mem_wren      : RAM enable and write enable (1 = write)
//   busy                  : high whenever the sequencer is not idle
//
// Parameters
//   WIDTH        : data and address width in bits
//   READ_LATENCY : RAM read latency in cycles, 1..4
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int WIDTH        = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             st_req,
    input  logic [WIDTH-1:0] st_addr,
    input  logic [WIDTH-1:0] st_data,
    output logic             st_done,
    input  logic             ld_req,
    input  logic [WIDTH-1:0] ld_addr,
    output logic [WIDTH-1:0] ld_data,
    output logic             ld_valid,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_ena,
    output logic             mem_wren,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_RESP  = 3'd3,
        S_LDONE = 3'd4
    } state_t;

    localparam logic GRANT_LOAD  = 1'b0;
    localparam logic GRANT_STORE = 1'b1;

    // Final count value of the READ phase.
    localparam logic [1:0] CNT_LAST = 2'(READ_LATENCY - 1);

    state_t           state_reg, state_next;
    logic [1:0]       cnt_reg, cnt_next;
    logic             last_grant_reg, last_grant_next;
    logic [WIDTH-1:0] addr_reg, addr_next;
    logic [WIDTH-1:0] wdata_reg, wdata_next;
    logic [WIDTH-1:0] ld_data_reg, ld_data_next;
    logic             ena_reg, ena_next;
    logic             wren_reg, wren_next;
    logic             st_done_reg, st_done_next;
    logic             ld_valid_reg, ld_valid_next;
    logic             busy_reg, busy_next;

    // Next-state, operand capture and output decode.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        last_grant_next = last_grant_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        ld_data_next    = ld_data_reg;

        case (state_reg)
            S_IDLE: begin
                // A store wins when it asks alone, or when both ask and the
                // load was granted last.
                if (st_req && (!ld_req || last_grant_reg == GRANT_LOAD)) begin
                    state_next      = S_WRITE;
                    addr_next       = st_addr;
                    wdata_next      = st_data;
                    last_grant_next = GRANT_STORE;
                end else if (ld_req) begin
                    state_next      = S_READ;
                    addr_next       = ld_addr;
                    cnt_next        = '0;
                    last_grant_next = GRANT_LOAD;
                end
            end
            S_WRITE: state_next = S_IDLE;
            S_READ: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = S_RESP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 2'd1;
                end
            end
            S_RESP: begin
                ld_data_next = mem_rdata;
                state_next   = S_LDONE;
            end
            S_LDONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        // Strobes are decoded from the next state and then registered, so
        // they line up with the state they belong to and never glitch.
        ena_next      = (state_next == S_WRITE) || (state_next == S_READ) ||
                        (state_next == S_RESP);
        wren_next     = (state_next == S_WRITE);
        st_done_next  = (state_next == S_WRITE);
        ld_valid_next = (state_next == S_LDONE);
        busy_next     = (state_next != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            last_grant_reg <= GRANT_LOAD;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            ld_data_reg    <= '0;
            ena_reg        <= 1'b0;
            wren_reg       <= 1'b0;
            st_done_reg    <= 1'b0;
            ld_valid_reg   <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            last_grant_reg <= last_grant_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            ld_data_reg    <= ld_data_next;
            ena_reg        <= ena_next;
            wren_reg       <= wren_next;
            st_done_reg    <= st_done_next;
            ld_valid_reg   <= ld_valid_next;
            busy_reg       <= busy_next;
        end
    end

    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign ld_data   = ld_data_reg;
    assign mem_ena   = ena_reg;
    assign mem_wren  = wren_reg;
    assign st_done   = st_done_reg;
    assign ld_valid  = ld_valid_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
//
// Two instances run side by side: dut0 with READ_LATENCY=1 and dut1 with
// READ_LATENCY=3, each attached to its own RAM model. A transaction-level
// model predicts every output on every cycle from the grant rules and the
// cycle offset since grant. Literal tables of committed stores and returned
// load words pin both the model and the DUTs.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    localparam int W = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]        rst, st_req, ld_req;
    logic [1:0]        st_done, ld_valid, mem_ena, mem_wren, busy;
    logic [1:0][W-1:0] st_addr, st_data, ld_addr;
    logic [1:0][W-1:0] ld_data, mem_addr, mem_wdata, mem_rdata;

    // RAM models
    logic [W-1:0] ram  [2][256];
    logic [W-1:0] pipe [2][4];
    logic         ram_ready = 1'b0;

    function automatic int rl_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [W-1:0] init_word(input int a);
        return 32'hA5A5_A500 | 32'(a);
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        dmem_access_ctrl #(
            .WIDTH       (W),
            .READ_LATENCY(gi == 0 ? 1 : 3)
        ) u_dut (
            .clock    (clock),
            .reset    (rst[gi]),
            .st_req   (st_req[gi]),
            .st_addr  (st_addr[gi]),
            .st_data  (st_data[gi]),
            .st_done  (st_done[gi]),
            .ld_req   (ld_req[gi]),
            .ld_addr  (ld_addr[gi]),
            .ld_data  (ld_data[gi]),
            .ld_valid (ld_valid[gi]),
            .mem_addr (mem_addr[gi]),
            .mem_wdata(mem_wdata[gi]),
            .mem_rdata(mem_rdata[gi]),
            .mem_ena  (mem_ena[gi]),
            .mem_wren (mem_wren[gi]),
            .busy     (busy[gi])
        );
        assign mem_rdata[gi] = pipe[gi][(gi == 0 ? 1 : 3) - 1];
    end

    // Synchronous RAM: sample on enabled read, output through a latency pipe.
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!ram_ready) begin
                for (int a = 0; a < 256; a++) ram[i][a] <= init_word(a);
            end else if (mem_ena[i] && mem_wren[i]) begin
                ram[i][mem_addr[i][7:0]] <= mem_wdata[i];
            end
            if (mem_ena[i] && !mem_wren[i]) pipe[i][0] <= ram[i][mem_addr[i][7:0]];
            for (int s = 1; s < 4; s++) pipe[i][s] <= pipe[i][s-1];
        end
        ram_ready <= 1'b1;
    end

    // ---------------- transaction-level model ----------------
    bit           m_ready = 1'b0;
    bit           m_act [2];
    bit           m_is_st [2];
    bit           m_last_st [2];
    int           m_c [2];
    logic [W-1:0] m_addr [2];
    logic [W-1:0] e_addr [2];
    logic [W-1:0] e_wdata [2];
    logic [W-1:0] e_ldd [2];
    logic [W-1:0] shadow [2][256];

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!m_ready) begin
                for (int a = 0; a < 256; a++) shadow[i][a] = init_word(a);
            end
            if (rst[i]) begin
                m_act[i] = 1'b0; m_c[i] = 0; m_last_st[i] = 1'b0;
                e_addr[i] = '0; e_wdata[i] = '0; e_ldd[i] = '0;
            end else if (m_act[i]) begin
                // Transaction in flight: advance the cycle offset since grant.
                m_c[i]++;
                if (!m_is_st[i] && m_c[i] == rl_of(i) + 2)
                    e_ldd[i] = shadow[i][m_addr[i][7:0]];
                if (m_c[i] > (m_is_st[i] ? 1 : rl_of(i) + 2))
                    m_act[i] = 1'b0;
            end else if (st_req[i] || ld_req[i]) begin
                m_is_st[i]   = st_req[i] && (!ld_req[i] || !m_last_st[i]);
                m_last_st[i] = m_is_st[i];
                m_act[i]     = 1'b1;
                m_c[i]       = 1;
                if (m_is_st[i]) begin
                    m_addr[i]  = st_addr[i];
                    e_addr[i]  = st_addr[i];
                    e_wdata[i] = st_data[i];
                    shadow[i][st_addr[i][7:0]] = st_data[i];
                end else begin
                    m_addr[i] = ld_addr[i];
                    e_addr[i] = ld_addr[i];
                end
            end
        end
        m_ready = 1'b1;
    end

    // ---------------- literal expectations ----------------
    logic [W-1:0] pin_st_addr [2][3] = '{'{32'h10, 32'h20, 32'h20}, '{32'h10, 32'h30, 32'h0}};
    logic [W-1:0] pin_st_data [2][3] = '{'{32'hDEADBEEF, 32'h11111111, 32'h22222222},
                                         '{32'hCAFEF00D, 32'h12345678, 32'h0}};
    logic [W-1:0] pin_ld [2][5] = '{'{32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'hDEADBEEF, 32'hDEADBEEF},
                                    '{32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 32'h0}};
    int n_st [2] = '{3, 2};
    int n_ld [2] = '{5, 1};

    // ---------------- compare process ----------------
    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int dut_sn [2] = '{0, 0};
    int dut_ln [2] = '{0, 0};
    int mod_sn [2] = '{0, 0};
    int mod_ln [2] = '{0, 0};
    bit sim_done = 1'b0;
    bit x_ena, x_wren, x_sd, x_lv, x_busy;

    task automatic check(input int i, input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %h, expected %h", name, i, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            x_busy = m_act[i];
            x_ena  = m_act[i] && (m_is_st[i] ? (m_c[i] == 1) : (m_c[i] <= rl_of(i) + 1));
            x_wren = m_act[i] && m_is_st[i];
            x_sd   = m_act[i] && m_is_st[i];
            x_lv   = m_act[i] && !m_is_st[i] && (m_c[i] == rl_of(i) + 2);

            check(i, "mem_ena",   32'(mem_ena[i]),  32'(x_ena));
            check(i, "mem_wren",  32'(mem_wren[i]), 32'(x_wren));
            check(i, "st_done",   32'(st_done[i]),  32'(x_sd));
            check(i, "ld_valid",  32'(ld_valid[i]), 32'(x_lv));
            check(i, "busy",      32'(busy[i]),     32'(x_busy));
            check(i, "mem_addr",  mem_addr[i],  e_addr[i]);
            check(i, "mem_wdata", mem_wdata[i], e_wdata[i]);
            check(i, "ld_data",   ld_data[i],   e_ldd[i]);

            if (x_sd) begin
                if (mod_sn[i] < n_st[i]) begin
                    check(i, "pin_model_st_addr", e_addr[i],  pin_st_addr[i][mod_sn[i]]);
                    check(i, "pin_model_st_data", e_wdata[i], pin_st_data[i][mod_sn[i]]);
                end
                mod_sn[i]++;
            end
            if (x_lv) begin
                if (mod_ln[i] < n_ld[i])
                    check(i, "pin_model_ld_data", e_ldd[i], pin_ld[i][mod_ln[i]]);
                mod_ln[i]++;
            end
            if (st_done[i]) begin
                $display("dut%0d cycle %0d store addr=%h data=%h", i, cyc, mem_addr[i], mem_wdata[i]);
                if (dut_sn[i] < n_st[i]) begin
                    check(i, "pin_st_addr", mem_addr[i],  pin_st_addr[i][dut_sn[i]]);
                    check(i, "pin_st_data", mem_wdata[i], pin_st_data[i][dut_sn[i]]);
                end
                dut_sn[i]++;
            end
            if (ld_valid[i]) begin
                $display("dut%0d cycle %0d load  data=%h", i, cyc, ld_data[i]);
                if (dut_ln[i] < n_ld[i])
                    check(i, "pin_ld_data", ld_data[i], pin_ld[i][dut_ln[i]]);
                dut_ln[i]++;
            end
        end

        if (sim_done || cyc > 4000) begin
            if (!sim_done) begin
                checks++;
                errors++;
                $display("FAIL timeout: got cycle %0d, expected stimulus end", cyc);
            end
            for (int i = 0; i < 2; i++) begin
                check(i, "store_count",       32'(dut_sn[i]), 32'(n_st[i]));
                check(i, "load_count",        32'(dut_ln[i]), 32'(n_ld[i]));
                check(i, "model_store_count", 32'(mod_sn[i]), 32'(n_st[i]));
                check(i, "model_load_count",  32'(mod_ln[i]), 32'(n_ld[i]));
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_store(input int i, input logic [W-1:0] a, input logic [W-1:0] d);
        @(negedge clock);
        st_req[i] = 1'b1; st_addr[i] = a; st_data[i] = d;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (st_done[i]) break;
        end
        st_req[i] = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    // Load from a; during the second cycle after grant the address input is
    // moved to alt to show the captured address is held.
    task automatic run_load(input int i, input logic [W-1:0] a, input logic [W-1:0] alt);
        @(negedge clock);
        ld_req[i] = 1'b1; ld_addr[i] = a;
        @(negedge clock);
        @(negedge clock);
        ld_addr[i] = alt;
        for (int n = 0; n < 20; n++) begin
            if (ld_valid[i]) break;
            @(negedge clock);
        end
        ld_req[i] = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        rst = 2'b11; st_req = '0; ld_req = '0;
        st_addr = '0; st_data = '0; ld_addr = '0;
        repeat (3) @(negedge clock);
        rst = 2'b00;

        // dut0 (latency 1): single store, single load
        run_store(0, 32'h10, 32'hDEADBEEF);
        run_load(0, 32'h10, 32'h30);

        // dut0: fresh reset, then both requests held -> strict alternation
        @(negedge clock);
        rst[0] = 1'b1;
        @(negedge clock);
        rst[0] = 1'b0;
        st_addr[0] = 32'h20; st_data[0] = 32'h11111111; ld_addr[0] = 32'h20;
        st_req[0] = 1'b1; ld_req[0] = 1'b1;
        repeat (3) @(negedge clock);
        st_data[0] = 32'h22222222;
        repeat (7) @(negedge clock);
        st_req[0] = 1'b0; ld_req[0] = 1'b0;
        repeat (8) @(negedge clock);

        // dut0: load request held across the completion cycle
        ld_addr[0] = 32'h10; ld_req[0] = 1'b1;
        repeat (6) @(negedge clock);
        ld_req[0] = 1'b0;
        repeat (6) @(negedge clock);

        // dut1 (latency 3): store, then load with the address input moved mid-read
        run_store(1, 32'h10, 32'hCAFEF00D);
        run_load(1, 32'h10, 32'h20);

        // dut1: reset in the second READ cycle aborts the load
        @(negedge clock);
        ld_addr[1] = 32'h10; ld_req[1] = 1'b1;
        @(negedge clock);
        @(negedge clock);
        rst[1] = 1'b1; ld_req[1] = 1'b0;
        @(negedge clock);
        rst[1] = 1'b0;
        repeat (2) @(negedge clock);
        run_store(1, 32'h30, 32'h12345678);

        repeat (4) @(negedge clock);
        sim_done = 1'b1;
    end

endmodule
